// File: rtl/parity_lanes_pkg.sv
// Shared constants and types for the parity_lanes block: error-counter width,
// its saturation value and the skid-buffer occupancy type.
package parity_lanes_pkg;

  localparam int ERRCNT_W = 16;
  localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = '1;

  typedef logic [1:0] fifo_cnt_t;

  localparam fifo_cnt_t FIFO_EMPTY = 2'd0;
  localparam fifo_cnt_t FIFO_ONE   = 2'd1;
  localparam fifo_cnt_t FIFO_FULL  = 2'd2;

endpackage

// File: rtl/parity_lanes_skid.sv
// Two-entry skid buffer with a registered in_ready, so out_ready never reaches
// in_ready combinationally. The head register holds its last value when empty.
module parity_lanes_skid
  import parity_lanes_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  fifo_cnt_t    count_q, count_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         push, pop;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    skid_d  = skid_q;
    push    = in_valid && in_ready_q;
    pop     = (count_q != FIFO_EMPTY) && out_ready;
    case (count_q)
      FIFO_EMPTY: begin
        if (push) begin
          head_d  = in_data;
          count_d = FIFO_ONE;
        end
      end
      FIFO_ONE: begin
        if (push && pop) begin
          head_d = in_data;
        end else if (push) begin
          skid_d  = in_data;
          count_d = FIFO_FULL;
        end else if (pop) begin
          count_d = FIFO_EMPTY;
        end
      end
      FIFO_FULL: begin
        // in_ready is low when full, so only a retire can happen here
        if (pop) begin
          head_d  = skid_q;
          count_d = FIFO_ONE;
        end
      end
      default: count_d = FIFO_EMPTY;
    endcase
    in_ready_d = (count_d != FIFO_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= FIFO_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != FIFO_EMPTY);
  assign out_data  = head_q;

endmodule

// File: rtl/parity_lanes.sv
// Per-lane parity checker with a 2-entry output skid buffer.
// Define PARITY_LANES_ERRCNT_EN to build the saturating mismatch counter.
module parity_lanes
  import parity_lanes_pkg::*;
#(
  parameter int LANES    = 8,
  parameter int LANE_W   = 2,
  parameter int COMMON_W = 8,
  parameter int ODD      = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [COMMON_W-1:0]     in_common,
  input  logic [LANES*LANE_W-1:0] in_lanes,
  input  logic [LANES-1:0]        in_expect,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_par,
  output logic [LANES-1:0]        out_mismatch,
  output logic [ERRCNT_W-1:0]     err_count
);

  if (LANES < 1 || LANES > 32) begin : g_bad_lanes
    $fatal(1, "parity_lanes: LANES must be 1..32");
  end
  if (LANE_W < 1 || LANE_W > 16) begin : g_bad_lane_w
    $fatal(1, "parity_lanes: LANE_W must be 1..16");
  end
  if (COMMON_W < 1 || COMMON_W > 64) begin : g_bad_common_w
    $fatal(1, "parity_lanes: COMMON_W must be 1..64");
  end
  if (ODD != 0 && ODD != 1) begin : g_bad_odd
    $fatal(1, "parity_lanes: ODD must be 0 or 1");
  end

  localparam logic ODD_BIT = (ODD != 0);

  logic             common_par;
  logic [LANES-1:0] par;
  logic [LANES-1:0] head_par;
  logic [LANES-1:0] head_mis;

  always_comb begin
    common_par = ^in_common;
    par        = '0;
    for (int k = 0; k < LANES; k++) begin
      par[k] = (^in_lanes[k*LANE_W +: LANE_W]) ^ common_par ^ ODD_BIT;
    end
  end

  parity_lanes_skid #(.W(2*LANES)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({par, par ^ in_expect}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({head_par, head_mis})
  );

  assign out_par      = head_par;
  assign out_mismatch = head_mis;

`ifdef PARITY_LANES_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (out_valid && out_ready && (|head_mis) && (err_count_q != ERRCNT_MAX)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = '0;
`endif

endmodule
